// File: rtl/ndn_pkg.sv
// Shared definitions for the N-input gate self-test: function codes, FSM states
// and the golden gate model used by both the engine and its checker.
package ndn_pkg;

  localparam int FN_NAND = 0;
  localparam int FN_NOR  = 1;
  localparam int FN_AND  = 2;
  localparam int FN_OR   = 3;

  localparam int VEC_MAX_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAIL  = 3'd4
  } state_e;

  // v is zero-extended to 16 bits; only the low n bits are gate inputs.
  function automatic logic expected_out(input int func, input logic [VEC_MAX_W-1:0] v,
                                        input int n);
    logic [VEC_MAX_W-1:0] mask;
    logic all_ones;
    logic any_one;
    mask     = 16'hFFFF >> (VEC_MAX_W - n);
    all_ones = ((v & mask) == mask);
    any_one  = |(v & mask);
    case (func)
      FN_NAND: expected_out = ~all_ones;
      FN_NOR:  expected_out = ~any_one;
      FN_AND:  expected_out = all_ones;
      default: expected_out = any_one;
    endcase
  endfunction

endpackage

// File: rtl/ndn_gate.sv
// Parametrised N-input gate under test; output is registered once so the
// engine always compares a flopped value.
module ndn_gate
  import ndn_pkg::*;
#(
  parameter int N    = 3,
  parameter int FUNC = FN_NAND
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  output logic         y
);

  logic [VEC_MAX_W-1:0] a_ext;

  assign a_ext = VEC_MAX_W'(a);

  always_ff @(posedge clk) begin
    if (rst) y <= 1'b0;
    else     y <= expected_out(FUNC, a_ext, N);
  end

endmodule

// File: rtl/ndn_selftest.sv
// Exhaustive self-test engine: walks every input vector of one ndn_gate,
// holding each for SETTLE cycles, and latches the first mismatch.
//
//  state | meaning
//  IDLE  | waiting for start, no status
//  APPLY | vector driven, settle counter running
//  CHECK | one-cycle compare of registered gate output
//  DONE  | all vectors matched
//  FAIL  | mismatch captured in fail_vec / fail_y
module ndn_selftest
  import ndn_pkg::*;
#(
  parameter int N      = 3,
  parameter int FUNC   = FN_NAND,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         inj_fault,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N-1:0] vec,
  output logic [N-1:0] fail_vec,
  output logic         fail_y,
  output logic         exp_y
);

  localparam logic [N-1:0] VEC_MAX     = {N{1'b1}};
  localparam logic [N-1:0] VEC_ONE     = N'(1);
  localparam logic [3:0]   SETTLE_LAST = 4'(SETTLE - 1);

  state_e       state_q;
  logic [3:0]   cnt_q;
  logic [N-1:0] vec_q;
  logic [N-1:0] fail_vec_q;
  logic         fail_y_q;
  logic         busy_q;
  logic         done_q;
  logic         pass_q;
  logic         gate_y;
  logic         obs;

  ndn_gate #(.N(N), .FUNC(FUNC)) u_gate (
    .clk (clk),
    .rst (rst),
    .a   (vec_q),
    .y   (gate_y)
  );

  assign obs   = gate_y ^ inj_fault;
  assign exp_y = expected_out(FUNC, VEC_MAX_W'(vec_q), N);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      vec_q      <= '0;
      fail_vec_q <= '0;
      fail_y_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start) begin
            state_q    <= ST_APPLY;
            cnt_q      <= 4'd0;
            vec_q      <= '0;
            fail_vec_q <= '0;
            fail_y_q   <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
          end
        end
        ST_APPLY: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == SETTLE_LAST) state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          // abort outranks the compare so a cancelled sweep never reports status
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (obs != exp_y) begin
            state_q    <= ST_FAIL;
            fail_vec_q <= vec_q;
            fail_y_q   <= obs;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            pass_q     <= 1'b0;
          end else if (vec_q == VEC_MAX) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
          end else begin
            state_q <= ST_APPLY;
            vec_q   <= vec_q + VEC_ONE;
            cnt_q   <= 4'd0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign vec      = vec_q;
  assign fail_vec = fail_vec_q;
  assign fail_y   = fail_y_q;

endmodule

// File: tb/tb_ndn_selftest.sv
// Bench for ndn_selftest: two configurations (3-in NAND, settle 1; 4-in NOR,
// settle 3) swept with random fault points and start noise against a cycle model.
module tb_ndn_selftest;

  logic clk = 1'b0;
  logic rst;
  logic start_a, abort_a, inj_a;
  logic busy_a, done_a, pass_a, fail_y_a, exp_a;
  logic [2:0] vec_a, fail_vec_a;
  logic start_b, abort_b, inj_b;
  logic busy_b, done_b, pass_b, fail_y_b, exp_b;
  logic [3:0] vec_b, fail_vec_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ndn_selftest #(.N(3), .FUNC(0), .SETTLE(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .inj_fault(inj_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .vec(vec_a),
    .fail_vec(fail_vec_a), .fail_y(fail_y_a), .exp_y(exp_a)
  );

  ndn_selftest #(.N(4), .FUNC(1), .SETTLE(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .inj_fault(inj_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .vec(vec_b),
    .fail_vec(fail_vec_b), .fail_y(fail_y_b), .exp_y(exp_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Gate truth from its definition: NAND/AND depend on all-ones, NOR/OR on any-one.
  function automatic bit ref_gate(input int func, input int v, input int n);
    bit all1;
    bit any1;
    all1 = (v == (1 << n) - 1);
    any1 = (v != 0);
    case (func)
      0: ref_gate = !all1;
      1: ref_gate = !any1;
      2: ref_gate = all1;
      default: ref_gate = any1;
    endcase
  endfunction

  // One sweep: inj_k = vector whose check sees an inverted output (-1: none).
  task automatic sweep(input int sel, input int inj_k, input bit inj_all, input bit noise,
                       input string tag);
    int s, n, func, cap, t, fk, done_edge, last_vec, v;
    bit seq_ok, b, d, ex, st, ij, chk_edge;
    s = sel ? 3 : 1;
    n = sel ? 4 : 3;
    func = sel ? 1 : 0;
    cap = (1 << n) * (s + 1);
    fk = inj_all ? 0 : inj_k;
    t = (fk >= 0) ? (fk + 1) * (s + 1) : cap;
    done_edge = -1;
    seq_ok = 1'b1;
    for (int e = 0; e <= cap + 4 && done_edge < 0; e++) begin
      chk_edge = (e > 0) && (e % (s + 1) == 0);
      st = (e == 0) || (noise && e < t && $urandom_range(0, 3) == 0);
      ij = inj_all || (inj_k >= 0 && e == t) || (noise && !chk_edge && $urandom_range(0, 1) == 1);
      if (sel) begin start_b = st; inj_b = ij; end
      else     begin start_a = st; inj_a = ij; end
      tick();
      b  = sel ? busy_b : busy_a;
      d  = sel ? done_b : done_a;
      ex = sel ? exp_b : exp_a;
      v  = sel ? int'(vec_b) : int'(vec_a);
      if (d) done_edge = e;
      else if (!b || v != e / (s + 1) || ex != ref_gate(func, e / (s + 1), n)) seq_ok = 1'b0;
    end
    start_a = 0; inj_a = 0; start_b = 0; inj_b = 0;
    last_vec = (fk >= 0) ? fk : (1 << n) - 1;
    chk({tag, "_done_edge"}, done_edge, t);
    chk({tag, "_busy_vec_seq"}, seq_ok, 1);
    chk({tag, "_pass"}, sel ? pass_b : pass_a, fk < 0);
    chk({tag, "_busy_after"}, sel ? busy_b : busy_a, 0);
    chk({tag, "_vec_hold"}, sel ? vec_b : vec_a, last_vec);
    chk({tag, "_exp_y"}, sel ? exp_b : exp_a, ref_gate(func, last_vec, n));
    chk({tag, "_fail_vec"}, sel ? fail_vec_b : fail_vec_a, fk >= 0 ? fk : 0);
    chk({tag, "_fail_y"}, sel ? fail_y_b : fail_y_a, fk >= 0 ? !ref_gate(func, fk, n) : 0);
  endtask

  initial begin
    int k, m;
    rst = 1; start_a = 0; abort_a = 0; inj_a = 0; start_b = 0; abort_b = 0; inj_b = 0;
    tick(); tick();
    chk("rst_a_outs", {busy_a, done_a, pass_a, vec_a, fail_vec_a, fail_y_a}, 0);
    chk("rst_b_outs", {busy_b, done_b, pass_b, vec_b, fail_vec_b, fail_y_b}, 0);
    chk("rst_a_exp_y", exp_a, ref_gate(0, 0, 3));
    rst = 0;
    tick();

    sweep(0, -1, 0, 0, "t1_nand_pass");
    abort_a = 1; tick(); abort_a = 0;
    chk("abort_in_done_ignored", {done_a, pass_a, busy_a}, 3'b110);

    sweep(0, 5, 0, 0, "t2_fault5");
    abort_a = 1; tick(); abort_a = 0;
    chk("abort_in_fail_ignored", {done_a, pass_a, fail_vec_a}, {2'b10, 3'd5});

    for (int i = 0; i < 6; i++) begin
      k = $urandom_range(0, 8);
      sweep(0, (k == 8) ? -1 : k, 0, 1, "rand_a");
    end

    sweep(1, -1, 0, 1, "t3_nor_pass");
    sweep(1, -1, 1, 0, "t3_nor_injall");

    start_a = 1; tick(); start_a = 0;
    for (int e = 1; e < 7; e++) tick();
    abort_a = 1; tick(); abort_a = 0;
    chk("t4_abort_edge7", {busy_a, done_a, pass_a}, 0);
    tick();
    chk("t4_abort_stays_idle", {busy_a, done_a, pass_a}, 0);

    m = $urandom_range(1, 14);
    start_a = 1; tick(); start_a = 0;
    for (int e = 1; e < m; e++) tick();
    start_a = 1; abort_a = 1; tick(); start_a = 0; abort_a = 0;
    chk("t4_start_abort_same", {busy_a, done_a, pass_a}, 0);
    tick();
    chk("t4_no_restart", busy_a, 0);

    sweep(0, 2, 0, 0, "pre_rst_fail");
    start_a = 1; tick(); start_a = 0;
    for (int e = 1; e < 9; e++) tick();
    rst = 1; tick(); rst = 0;
    chk("t5_rst_mid_sweep", {busy_a, done_a, pass_a, vec_a, fail_vec_a, fail_y_a}, 0);
    tick();
    chk("t5_rst_idle", {busy_a, done_a}, 0);
    sweep(0, -1, 0, 1, "t5_after_rst");
    sweep(0, -1, 0, 1, "t6_rerun");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
